// File: rtl/student_fir_sample_ctrl.sv
// Sample history controller for a FIR engine: writes each accepted sample into a
// circular DPRAM buffer, then streams the NumTaps most recent samples newest-first.
module student_fir_sample_ctrl #(
    parameter int AddrWidth = 10,
    parameter int DataSize  = 16,
    parameter int NumTaps   = 2**AddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_valid_i,
    input  logic [DataSize-1:0]  sample_i,
    output logic                 sample_ready_o,
    output logic                 ena_o,
    output logic                 wea_o,
    output logic [AddrWidth-1:0] addra_o,
    output logic [DataSize-1:0]  dia_o,
    output logic                 enb_o,
    output logic [AddrWidth-1:0] addrb_o,
    input  logic [DataSize-1:0]  dob_i,
    output logic                 tap_valid_o,
    output logic [DataSize-1:0]  tap_data_o,
    output logic [AddrWidth:0]   tap_idx_o,
    output logic                 tap_last_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam int TapW = AddrWidth + 1;
    localparam logic [AddrWidth:0] LastTap = TapW'(NumTaps - 1);

    state_t               state;
    state_t               state_next;
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] addra_q;
    logic [AddrWidth-1:0] addrb_q;
    logic [DataSize-1:0]  dia_q;
    logic [AddrWidth:0]   tap_cnt;
    logic [AddrWidth:0]   tap_idx_q;
    logic                 tap_valid_q;
    logic                 overrun_q;
    logic                 last_read;

    assign last_read = (tap_cnt == LastTap);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next     = state;
        sample_ready_o = 1'b0;
        busy_o         = 1'b1;
        ena_o          = 1'b0;
        wea_o          = 1'b0;
        enb_o          = 1'b0;
        case (state)
            IDLE: begin
                sample_ready_o = 1'b1;
                busy_o         = 1'b0;
                if (sample_valid_i) state_next = WRITE;
            end
            WRITE: begin
                ena_o      = 1'b1;
                wea_o      = 1'b1;
                state_next = READ;
            end
            READ: begin
                enb_o = 1'b1;
                if (last_read) state_next = DRAIN;
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address/data registers are loaded one cycle ahead so they are stable while the
    // enables are high and simply hold their last value otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            addra_q     <= '0;
            addrb_q     <= '0;
            dia_q       <= '0;
            tap_cnt     <= '0;
            tap_idx_q   <= '0;
            tap_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state       <= state_next;
            tap_valid_q <= (state == READ);
            if (state == IDLE && sample_valid_i) begin
                addra_q <= wr_ptr;
                dia_q   <= sample_i;
            end
            if (state == WRITE) begin
                wr_ptr  <= wr_ptr + AddrWidth'(1);
                addrb_q <= wr_ptr;
                tap_cnt <= '0;
            end
            if (state == READ) begin
                tap_cnt   <= tap_cnt + TapW'(1);
                tap_idx_q <= tap_cnt;
                if (!last_read) addrb_q <= addrb_q - AddrWidth'(1);
            end
            // A strobe outside IDLE is dropped; only the sticky flag records it.
            if (sample_valid_i && state != IDLE) overrun_q <= 1'b1;
        end
    end

    assign addra_o     = addra_q;
    assign dia_o       = dia_q;
    assign addrb_o     = addrb_q;
    assign tap_valid_o = tap_valid_q;
    assign tap_idx_o   = tap_idx_q;
    assign tap_last_o  = tap_valid_q && (tap_idx_q == LastTap);
    assign tap_data_o  = dob_i;
    assign overrun_o   = overrun_q;

endmodule
